serial_adder: RTL and testbench

- Bit-serial ripple adder that computes A + B one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop.
- It is the addition counterpart to the team's full subtractor: same one-bit cell style, iterated over a WIDTH-bit word.
- Sits as a small arithmetic slave behind a start/done handshake, for area-constrained datapaths.

---
 rtl/serial_adder.sv | 127 ++++++++++++
 tb/tb_serial_adder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, behind a start/done handshake.
// Optional macro SERIAL_ADDER_OVF_EN adds the registered signed-overflow output ovf.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] s_msb;

    always_comb begin
        s_bit  = a_q[0] ^ b_q[0] ^ c_q;
        c_next = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        // The new sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
        s_msb            = '0;
        s_msb[WIDTH-1]   = s_bit;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                sum_d = (sum_q >> 1) | s_msb;
                c_d   = c_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cout_d  = c_next;
`ifdef SERIAL_ADDER_OVF_EN
                    // On the last shift c_q is the carry into the MSB.
                    ovf_d   = c_q ^ c_next;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, corner sequences, back-to-back and random ops.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_in),
        .b     (b_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition and the signed-overflow rule on operand/result signs.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] r;
        r = ref_add(x, y);
        return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    logic [W-1:0] op_s;
    logic         op_c;
    logic         op_v;
    int           op_busy;
    bit           op_got;
    logic         op_done_after;

    // Issues one op from IDLE and returns the result seen in the done cycle.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        a_in  = x;
        b_in  = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        op_busy = 0;
        op_got  = 1'b0;
        op_s = '0; op_c = 1'b0; op_v = 1'b0;
        for (int k = 0; k < W + 5; k++) begin
            if (done) begin
                op_got = 1'b1;
                op_s = sum;
                op_c = cout;
`ifdef SERIAL_ADDER_OVF_EN
                op_v = ovf;
`endif
                if (busy) op_busy += 100;
                break;
            end
            if (busy) op_busy++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        op_done_after = done;
    endtask

    vec_t tbl[7];
    int   done_edges[$];
    logic [W:0] done_vals[$];
    logic [W-1:0] av[200];
    logic [W-1:0] bv[200];
    int   n_done;
    bit   saw_done;
    logic [W:0] r;

    initial begin
        tbl[0] = '{a: 8'h5A, b: 8'h33, s: 8'h8D, c: 1'b0, v: 1'b1};
        tbl[1] = '{a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1, v: 1'b0};
        tbl[2] = '{a: 8'hFF, b: 8'hFF, s: 8'hFE, c: 1'b1, v: 1'b0};
        tbl[3] = '{a: 8'h7F, b: 8'h01, s: 8'h80, c: 1'b0, v: 1'b1};
        tbl[4] = '{a: 8'h80, b: 8'h80, s: 8'h00, c: 1'b1, v: 1'b1};
        tbl[5] = '{a: 8'h40, b: 8'h20, s: 8'h60, c: 1'b0, v: 1'b0};
        tbl[6] = '{a: 8'h00, b: 8'h00, s: 8'h00, c: 1'b0, v: 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_sum", 32'(sum), 0);
        check("reset_cout", 32'(cout), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i].a, tbl[i].b);
            check($sformatf("tbl%0d_done", i), 32'(op_got), 1);
            check($sformatf("tbl%0d_busy_cycles", i), 32'(op_busy), W);
            check($sformatf("tbl%0d_sum", i), 32'(op_s), 32'(tbl[i].s));
            check($sformatf("tbl%0d_cout", i), 32'(op_c), 32'(tbl[i].c));
            check($sformatf("tbl%0d_done_pulse", i), 32'(op_done_after), 0);
`ifdef SERIAL_ADDER_OVF_EN
            check($sformatf("tbl%0d_ovf", i), 32'(op_v), 32'(tbl[i].v));
`endif
        end
        check("hold_sum", 32'(sum), 0);
        check("hold_cout", 32'(cout), 0);

        // Start while busy: second request in the third SHIFT cycle must be dropped.
        @(negedge clk);
        start = 1'b1; a_in = 8'h5A; b_in = 8'h33;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; a_in = 8'h01; b_in = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0;
        for (int k = 0; k < 3 * W; k++) begin
            if (done) begin
                n_done++;
                check("busy_start_sum", 32'(sum), 32'h8D);
            end
            @(posedge clk); #1;
        end
        check("busy_start_done_count", 32'(n_done), 1);

        // Reset in the fourth SHIFT cycle clears everything asynchronously.
        do_op(8'hC3, 8'h5E);
        @(negedge clk);
        start = 1'b1; a_in = 8'hAA; b_in = 8'h77;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_sum", 32'(sum), 0);
        check("midrst_cout", 32'(cout), 0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("midrst_no_done", 32'(saw_done), 0);
        do_op(8'h9C, 8'h81);
        r = ref_add(8'h9C, 8'h81);
        check("after_rst_done", 32'(op_got), 1);
        check("after_rst_result", 32'({op_c, op_s}), 32'(r));

        // Back-to-back: start held high, operands changing every cycle.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = 1'b1;
            a_in = W'($urandom);
            b_in = W'($urandom);
            av[i] = a_in;
            bv[i] = b_in;
            @(posedge clk); #1;
            if (done) begin
                done_edges.push_back(i);
                done_vals.push_back({cout, sum});
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("b2b_count", 32'(done_edges.size()), 32'((200 - W - 1) / (W + 2) + 1));
        for (int n = 0; n < done_edges.size(); n++) begin
            check($sformatf("b2b%0d_edge", n), 32'(done_edges[n]), 32'(n * (W + 2) + W));
            check($sformatf("b2b%0d_val", n), 32'(done_vals[n]),
                  32'(ref_add(av[n * (W + 2)], bv[n * (W + 2)])));
        end
        repeat (W + 3) @(posedge clk);

        // Random single ops against the arithmetic model.
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] x, y;
            x = W'($urandom);
            y = W'($urandom);
            if (i < 4) begin
                x = (i[0]) ? 8'hFF : 8'h00;
                y = (i[1]) ? 8'hFF : 8'h00;
            end
            do_op(x, y);
            r = ref_add(x, y);
            check($sformatf("rnd%0d_done", i), 32'(op_got), 1);
            check($sformatf("rnd%0d_result", i), 32'({op_c, op_s}), 32'(r));
`ifdef SERIAL_ADDER_OVF_EN
            check($sformatf("rnd%0d_ovf", i), 32'(op_v), 32'(ref_ovf(x, y)));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
